// File: rtl/jtgng_prom_bank.sv
// Banked PROM loaded through a flat download port, one registered read port per bank.
// Define JTGNG_PROM_CRC_EN to build the CRC-16/CCITT checksum of the downloaded bytes.
module jtgng_prom_bank #(
   parameter int unsigned DW     = 4,
   parameter int unsigned AW     = 8,
   parameter int unsigned BANKS  = 2,
   parameter int unsigned CEN_RD = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cen,
   input  logic                downloading,
   input  logic                prog_we,
   input  logic [AW+1:0]       prog_addr,
   input  logic [7:0]          prog_data,
   input  logic [BANKS*AW-1:0] rd_addr,
   output logic [BANKS*DW-1:0] q,
   output logic                prog_done,
   output logic                prog_err,
   output logic [AW+2:0]       prog_cnt,
   output logic [15:0]         prog_crc
);

   localparam int unsigned CntW = AW + 3;

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e          state_q;
   logic [1:0]      wr_bank;
   logic [AW-1:0]   wr_idx;
   logic            entering;
   logic            accept;
   logic            bank_ok;
   logic            rd_en;
   logic [CntW-1:0] cnt_base;
   logic [CntW-1:0] cnt_next;
   logic            err_next;

   logic            pend_valid;
   logic [1:0]      pend_bank;
   logic [AW-1:0]   pend_idx;
   logic [DW-1:0]   pend_data;

   assign wr_bank  = prog_addr[AW+1:AW];
   assign wr_idx   = prog_addr[AW-1:0];
   assign entering = (state_q != StLoad) && downloading;
   // The IDLE/DONE->LOAD transition cycle already accepts a write.
   assign accept   = prog_we && ((state_q == StLoad) || downloading);
   assign bank_ok  = {1'b0, wr_bank} < 3'(BANKS);
   assign rd_en    = (CEN_RD == 0) || cen;

   always_comb begin
      cnt_base = entering ? '0 : prog_cnt;
      cnt_next = cnt_base;
      if (accept && (cnt_base != '1)) cnt_next = cnt_base + CntW'(1);
      err_next = (entering ? 1'b0 : prog_err) | (accept & ~bank_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         prog_done  <= 1'b0;
         prog_err   <= 1'b0;
         prog_cnt   <= '0;
         pend_valid <= 1'b0;
         pend_bank  <= '0;
         pend_idx   <= '0;
         pend_data  <= '0;
      end else begin
         unique case (state_q)
            StIdle:  if (downloading)  state_q <= StLoad;
            StLoad:  if (!downloading) state_q <= StDone;
            StDone:  if (downloading)  state_q <= StLoad;
            default: state_q <= StIdle;
         endcase
         // Rises one edge after entering DONE, i.e. after the last pending commit.
         prog_done  <= (state_q == StDone) && !downloading;
         prog_cnt   <= cnt_next;
         prog_err   <= err_next;
         pend_valid <= accept && bank_ok;
         if (accept) begin
            pend_bank <= wr_bank;
            pend_idx  <= wr_idx;
            pend_data <= prog_data[DW-1:0];
         end
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [DW-1:0] mem [2**AW];
      logic [DW-1:0] q_q;
      logic [AW-1:0] raddr;

      assign raddr = rd_addr[b*AW +: AW];

      // Contents are not reset so they survive rst_n.
      always_ff @(posedge clk) begin
         if (pend_valid && (pend_bank == 2'(b))) mem[pend_idx] <= pend_data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)     q_q <= '0;
         else if (rd_en) q_q <= mem[raddr];
      end

      assign q[b*DW +: DW] = q_q;
   end

`ifdef JTGNG_PROM_CRC_EN
   logic [15:0] crc_q;
   logic [15:0] crc_base;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   assign crc_base = entering ? 16'hFFFF : crc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      crc_q <= 16'hFFFF;
      else if (accept) crc_q <= crc_byte(crc_base, prog_data);
      else             crc_q <= crc_base;
   end

   assign prog_crc = crc_q;
`else
   assign prog_crc = 16'h0000;
`endif

   logic unused_data;
   assign unused_data = ^prog_data;

endmodule

// File: tb/tb_jtgng_prom_bank.sv
// Scoreboard bench for jtgng_prom_bank: stimulus queues expectations tagged with a cycle,
// a negedge monitor pops and compares them against two instances (CEN_RD=0 and CEN_RD=1).
module tb_jtgng_prom_bank;

   localparam int SelQ0  = 0;
   localparam int SelQ1  = 1;
   localparam int SelCq0 = 2;
   localparam int SelDone = 3;
   localparam int SelErr = 4;
   localparam int SelCnt = 5;
   localparam int SelCrc = 6;

`ifdef JTGNG_PROM_CRC_EN
   localparam logic [15:0] CrcRst = 16'hFFFF;
   localparam logic [15:0] CrcStr = 16'h29B1;
`else
   localparam logic [15:0] CrcRst = 16'h0000;
   localparam logic [15:0] CrcStr = 16'h0000;
`endif

   typedef struct {
      string       name;
      int          sel;
      logic [15:0] exp;
      int          cyc;
   } chk_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cen;
   logic        downloading;
   logic        prog_we;
   logic [9:0]  prog_addr;
   logic [7:0]  prog_data;
   logic [15:0] rd_addr;
   logic [7:0]  q, cq;
   logic        prog_done, cprog_done;
   logic        prog_err, cprog_err;
   logic [10:0] prog_cnt, cprog_cnt;
   logic [15:0] prog_crc, cprog_crc;

   chk_t sb[$];
   chk_t e;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   jtgng_prom_bank #(.DW(4), .AW(8), .BANKS(2), .CEN_RD(0)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .downloading(downloading), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .rd_addr(rd_addr), .q(q),
      .prog_done(prog_done), .prog_err(prog_err), .prog_cnt(prog_cnt), .prog_crc(prog_crc)
   );

   jtgng_prom_bank #(.DW(4), .AW(8), .BANKS(2), .CEN_RD(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .cen(cen), .downloading(downloading), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .rd_addr(rd_addr), .q(cq),
      .prog_done(cprog_done), .prog_err(cprog_err), .prog_cnt(cprog_cnt),
      .prog_crc(cprog_crc)
   );

   function automatic logic [15:0] observe(input int sel);
      case (sel)
         SelQ0:   return {12'd0, q[3:0]};
         SelQ1:   return {12'd0, q[7:4]};
         SelCq0:  return {12'd0, cq[3:0]};
         SelDone: return {15'd0, prog_done};
         SelErr:  return {15'd0, prog_err};
         SelCnt:  return {5'd0, prog_cnt};
         default: return prog_crc;
      endcase
   endfunction

   // Monitor: compares every expectation due in the cycle just clocked.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         logic [15:0] act;
         e = sb.pop_front();
         act = observe(e.sel);
         n_tests++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string n, input int sel, input logic [15:0] v);
      chk_t c;
      c.name = n;
      c.sel  = sel;
      c.exp  = v;
      c.cyc  = cyc;
      sb.push_back(c);
   endtask

   task automatic wr(input logic [9:0] a, input logic [7:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
   endtask

   task automatic idle_in();
      prog_we     = 1'b0;
      downloading = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] a;
      logic [7:0] str [9];
      str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      rst_n = 1'b0; cen = 1'b0; downloading = 1'b0; prog_we = 1'b0;
      prog_addr = '0; prog_data = '0; rd_addr = '0;
      tick(); tick();
      expect_now("rst_q0", SelQ0, 16'h0);
      expect_now("rst_q1", SelQ1, 16'h0);
      expect_now("rst_done", SelDone, 16'h0);
      expect_now("rst_err", SelErr, 16'h0);
      expect_now("rst_cnt", SelCnt, 16'h0);
      expect_now("rst_crc", SelCrc, CrcRst);
      tick();
      rst_n = 1'b1;
      tick();

      // Full 512-byte download
      downloading = 1'b1;
      for (int i = 0; i < 512; i++) begin
         a = 10'(i);
         wr(a, a[7:0] ^ {7'd0, a[8]});
      end
      idle_in();
      tick();
      expect_now("done_not_yet", SelDone, 16'h0);
      tick();
      expect_now("done_set", SelDone, 16'h1);
      expect_now("cnt_512", SelCnt, 16'd512);
      expect_now("err_clear", SelErr, 16'h0);
      n_tests++;
      if (prog_done !== 1'b1) begin
         n_fail++;
         $display("FAIL direct_done: got %b, expected 1", prog_done);
      end
      n_tests++;
      if (prog_cnt !== 11'd512) begin
         n_fail++;
         $display("FAIL direct_cnt: got %0d, expected 512", prog_cnt);
      end
      n_tests++;
      if (cprog_cnt !== prog_cnt) begin
         n_fail++;
         $display("FAIL inst_cnt: got %0d, expected %0d", cprog_cnt, prog_cnt);
      end
      rd_addr = {8'h35, 8'h35};
      tick();
      expect_now("bank0_35", SelQ0, 16'h5);
      expect_now("bank1_35", SelQ1, 16'h4);
      rd_addr = {8'hFF, 8'hFF};
      tick();
      expect_now("bank0_ff", SelQ0, 16'hF);
      expect_now("bank1_ff", SelQ1, 16'hE);

      // Out-of-range bank write on the DONE->LOAD cycle
      downloading = 1'b1;
      wr(10'h300, 8'h77);
      expect_now("bad_bank_err", SelErr, 16'h1);
      expect_now("bad_bank_cnt", SelCnt, 16'h1);
      expect_now("load_done_low", SelDone, 16'h0);
      n_tests++;
      if (prog_err !== 1'b1) begin
         n_fail++;
         $display("FAIL direct_err: got %b, expected 1", prog_err);
      end
      idle_in();
      tick(); tick();
      expect_now("err_sticky", SelErr, 16'h1);
      rd_addr = {8'h00, 8'h00};
      tick();
      expect_now("bad_bank_b0", SelQ0, 16'h0);
      expect_now("bad_bank_b1", SelQ1, 16'h1);
      downloading = 1'b1;
      tick();
      expect_now("new_win_err", SelErr, 16'h0);
      expect_now("new_win_cnt", SelCnt, 16'h0);
      downloading = 1'b0;
      tick();

      // Read-before-write on bank0[0x10]
      downloading = 1'b1;
      wr(10'h010, 8'h03);
      wr(10'h010, 8'h0A);
      prog_we = 1'b0;
      rd_addr = {8'h00, 8'h10};
      tick();
      expect_now("rbw_old", SelQ0, 16'h3);
      tick();
      expect_now("rbw_new", SelQ0, 16'hA);
      idle_in();
      tick();

      // Read clock enable on the CEN_RD=1 instance
      cen = 1'b0;
      rd_addr = {8'h00, 8'h35};
      tick();
      expect_now("cen0_hold_a", SelCq0, 16'h0);
      rd_addr = {8'h00, 8'hFF};
      tick();
      expect_now("cen0_hold_b", SelCq0, 16'h0);
      cen = 1'b1;
      tick();
      expect_now("cen1_update", SelCq0, 16'hF);
      cen = 1'b0;
      rd_addr = {8'h00, 8'h35};
      tick();
      expect_now("cen0_hold_c", SelCq0, 16'hF);

      // CRC of "123456789"
      downloading = 1'b1;
      for (int i = 0; i < 9; i++) wr(10'(i), str[i]);
      expect_now("crc_str", SelCrc, CrcStr);
      expect_now("crc_cnt", SelCnt, 16'd9);
      n_tests++;
      if (cprog_crc !== prog_crc) begin
         n_fail++;
         $display("FAIL inst_crc: got %h, expected %h", cprog_crc, prog_crc);
      end
      idle_in();
      tick(); tick();

      // Reset with a write pending
      downloading = 1'b1;
      wr(10'h020, 8'h06);
      wr(10'h021, 8'h07);
      idle_in();
      rst_n = 1'b0;
      #1;
      expect_now("mid_rst_cnt", SelCnt, 16'h0);
      expect_now("mid_rst_err", SelErr, 16'h0);
      expect_now("mid_rst_done", SelDone, 16'h0);
      expect_now("mid_rst_crc", SelCrc, CrcRst);
      expect_now("mid_rst_q0", SelQ0, 16'h0);
      tick();
      rst_n = 1'b1;
      rd_addr = {8'h00, 8'h21};
      tick();
      expect_now("pending_dropped", SelQ0, 16'h1);
      rd_addr = {8'h00, 8'h20};
      tick();
      expect_now("earlier_kept", SelQ0, 16'h6);
      rd_addr = {8'h00, 8'h10};
      tick();
      expect_now("old_kept", SelQ0, 16'hA);

      for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s: got no sample, expected %h", e.name, e.exp);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
